// File: rtl/dcache_pkg.sv
// dcache_pkg: constants, FSM state encoding and word helpers shared by the
// data cache top (data_cache) and its storage array (data_cache_array).
//   WORD_W     : processor word width (32)
//   LINE_W     : cache line width, four words (128)
//   ADDR_W     : processor word-address width (30)
//   MEM_ADDR_W : line address width seen by memory (28)
//   state_t    : IDLE / WRITEBACK / ALLOCATE
package dcache_pkg;

  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int OFFSET_W   = 2;
  localparam int ADDR_W     = 30;
  localparam int MEM_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Extract word 'off' of a line; word k lives on bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  // Replace word 'off' of a line with 'data', leaving the other words intact.
  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] off,
                                                 input logic [WORD_W-1:0] data);
    logic [LINE_W-1:0] l;
    l = line;
    case (off)
      2'd0:    l[31:0]   = data;
      2'd1:    l[63:32]  = data;
      2'd2:    l[95:64]  = data;
      default: l[127:96] = data;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// data_cache_array: tag, valid, dirty and data storage for the direct-mapped
// data cache. One synchronous write port updates a whole line entry (tag,
// data, valid=1, dirty) at once; one asynchronous read port returns the entry
// at rd_idx. Valid and dirty bits are cleared by reset; tag and data are not.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en, wr_idx         : write strobe and line index
//   wr_tag, wr_dirty      : tag and dirty bit written with the line
//   wr_line               : full 128-bit line written
//   rd_idx                : read index
//   rd_valid, rd_dirty    : status of the addressed line
//   rd_tag, rd_line       : stored tag and line of the addressed line
module data_cache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_dirty,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // Status bits: reset clears every line, any write makes the line valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data storage carry no reset; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with four
// 32-bit words per line. Hits complete combinationally in IDLE; misses evict a
// dirty victim (WRITEBACK) and then fill the line (ALLOCATE) before the
// request completes as a hit.
// Optional feature macro: DCACHE_FILL_BYPASS_EN -- when defined, the request
// completes in the ALLOCATE cycle that sees mem_ready (read data forwarded
// from mem_rdata, store data merged into the fill line as dirty).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   proc_read, proc_write      : processor load / store request
//   proc_addr [29:0]           : word address {tag, index, word offset}
//   proc_wdata [31:0]          : store data
//   proc_stall                 : request not yet complete
//   proc_rdata [31:0]          : load data
//   mem_read, mem_write        : line fill / line writeback request
//   mem_addr [27:0]            : line address {tag, index}
//   mem_wdata [127:0]          : writeback line
//   mem_rdata [127:0]          : fill line, valid with mem_ready
//   mem_ready                  : one-cycle completion pulse
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic                  proc_stall,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

  state_t state_q, state_d;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                req;
  logic                hit;

  logic                wr_en;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_dirty;
  logic [LINE_W-1:0]   wr_line;
  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;

  assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFFSET_W];
  assign req_idx = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign req_off = proc_addr[OFFSET_W-1:0];
  assign req     = proc_read | proc_write;
  assign hit     = req & rd_valid & (rd_tag == req_tag);

  // The array is always looked up at the request index; the processor holds
  // its address through a miss, so this also selects the victim and fill slot.
  data_cache_array #(
    .NUM_LINES(NUM_LINES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (req_idx),
    .wr_tag  (wr_tag),
    .wr_dirty(wr_dirty),
    .wr_line (wr_line),
    .rd_idx  (req_idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_line (rd_line)
  );

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a miss evicts first only when the victim is dirty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and array-write logic. Every output is forced to zero while rst_n
  // is low so memory requests drop immediately, not at the next clock.
  // proc_write wins over proc_read, so a simultaneous request is a store.
  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    wr_tag     = req_tag;
    wr_dirty   = 1'b0;
    wr_line    = rd_line;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          proc_rdata = get_word(rd_line, req_off);
          if (req) begin
            if (hit) begin
              if (proc_write) begin
                wr_en    = 1'b1;
                wr_dirty = 1'b1;
                wr_line  = put_word(rd_line, req_off, proc_wdata);
              end
            end else begin
              proc_stall = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          proc_stall = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {rd_tag, req_idx};
          mem_wdata  = rd_line;
        end
        ALLOCATE: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = {req_tag, req_idx};
          if (mem_ready) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b0;
            wr_line  = mem_rdata;
`ifdef DCACHE_FILL_BYPASS_EN
            // Finish the request straight from the fill data.
            proc_stall = 1'b0;
            if (proc_write) begin
              wr_dirty = 1'b1;
              wr_line  = put_word(mem_rdata, req_off, proc_wdata);
            end else begin
              proc_rdata = get_word(mem_rdata, req_off);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. A memory responder
// answers fills and writebacks after MEM_LAT cycles from a backing store.
// Expected load data and expected memory transactions are pushed onto
// scoreboard queues when each request is issued and popped as the DUT
// produces them. A golden word-level view of memory (backing store overlaid
// with stores not yet known to be written back) supplies expected data, and a
// small tag/valid/dirty model predicts hits, evictions and stall length.
module tb_data_cache;

  localparam int MEM_LAT = 5;
`ifdef DCACHE_FILL_BYPASS_EN
  localparam int FILL_EXTRA = 0;
`else
  localparam int FILL_EXTRA = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  data_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc_read (proc_read),
    .proc_write(proc_write),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_stall(proc_stall),
    .proc_rdata(proc_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_wr;
    logic [27:0]  addr;
    logic [127:0] line;
  } txn_t;

  txn_t        exp_txn[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] backing [logic [29:0]];
  logic [31:0] pending [logic [29:0]];
  logic        m_valid [8];
  logic        m_dirty [8];
  int          m_tag   [8];

  int checks_total  = 0;
  int checks_passed = 0;

  // Single comparison point: count it and report any mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Power-on memory image: line 4 holds {4,3,2,1}, others a line/word pattern.
  function automatic logic [31:0] init_word(input logic [29:0] wa);
    logic [27:0] la;
    la = wa[29:2];
    if (la == 28'h4) return 32'(wa[1:0]) + 32'd1;
    return {la[23:0], 6'd0, wa[1:0]} + 32'd1;
  endfunction

  function automatic logic [31:0] backing_word(input logic [29:0] wa);
    if (backing.exists(wa)) return backing[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] golden_word(input logic [29:0] wa);
    if (pending.exists(wa)) return pending[wa];
    return backing_word(wa);
  endfunction

  function automatic logic [127:0] golden_line(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = golden_word({la, 2'(k)});
    return l;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    pending.delete();
    exp_txn.delete();
    exp_rdata.delete();
  endtask

  // Memory responder: completes each mem_read/mem_write after MEM_LAT cycles.
  initial begin
    int   cnt;
    txn_t t;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          cnt = 0;
          checkOutput("rd_wr_excl", {127'd0, mem_read & mem_write}, 128'd0);
          if (exp_txn.size() == 0) begin
            checkOutput("unexpected_txn", {100'd0, mem_addr}, 128'hFFFF_FFFF);
          end else begin
            t = exp_txn.pop_front();
            checkOutput("txn_is_write", {127'd0, mem_write}, {127'd0, t.is_wr});
            checkOutput("txn_addr", {100'd0, mem_addr}, {100'd0, t.addr});
            if (t.is_wr) checkOutput("wb_line", mem_wdata, t.line);
          end
          if (mem_write) begin
            for (int k = 0; k < 4; k++) backing[{mem_addr, 2'(k)}] = mem_wdata[k*32 +: 32];
          end else begin
            for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] = backing_word({mem_addr, 2'(k)});
          end
          mem_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Issue one request: predict traffic, stall length and load data from the
  // model, then drive the request until the stall clears.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [29:0] addr, input logic [31:0] wdata);
    int   idx, tag, exp_cycles, cycles;
    txn_t t;
    idx = int'(addr[4:2]);
    tag = int'(addr[29:5]);
    exp_cycles = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      exp_cycles = MEM_LAT + FILL_EXTRA;
      if (m_valid[idx] && m_dirty[idx]) begin
        t.is_wr = 1'b1;
        t.addr  = {23'(m_tag[idx]), 3'(idx)};
        t.line  = golden_line(t.addr);
        exp_txn.push_back(t);
        exp_cycles += MEM_LAT;
      end
      t.is_wr = 1'b0;
      t.addr  = addr[29:2];
      t.line  = '0;
      exp_txn.push_back(t);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (wr) begin
      pending[addr] = wdata;
      m_dirty[idx]  = 1'b1;
    end else begin
      exp_rdata.push_back(golden_word(addr));
    end

    @(negedge clk);
    #1;
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wdata;
    cycles     = 0;
    #1;
    while (proc_stall && cycles < 200) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    checkOutput("stall_done", {127'd0, proc_stall}, 128'd0);
    checkOutput("stall_cycles", 128'(cycles), 128'(exp_cycles));
    if (!wr && exp_rdata.size() > 0) begin
      checkOutput("rdata", {96'd0, proc_rdata}, {96'd0, exp_rdata.pop_front()});
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    int cycles;
    rst_n      = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    clear_model();

    // Reset state, with a pending read presented to show outputs stay quiet.
    #2;
    rst_n     = 1'b0;
    proc_read = 1'b1;
    proc_addr = 30'h0000010;
    #1;
    checkOutput("rst_stall",  {127'd0, proc_stall}, 128'd0);
    checkOutput("rst_mem_rd", {127'd0, mem_read},   128'd0);
    checkOutput("rst_mem_wr", {127'd0, mem_write},  128'd0);
    checkOutput("rst_maddr",  {100'd0, mem_addr},   128'd0);
    checkOutput("rst_mwdata", mem_wdata,            128'd0);
    checkOutput("rst_rdata",  {96'd0, proc_rdata},  128'd0);
    proc_read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Cold read miss, write hit, read-back, then dirty eviction.
    applyStimulus(1'b1, 1'b0, 30'h0000010, 32'h0);
    applyStimulus(1'b0, 1'b1, 30'h0000011, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 30'h0000011, 32'h0);
    applyStimulus(1'b1, 1'b0, 30'h0000211, 32'h0);

    // Reset in the middle of a fill: mem_read must drop at once.
    @(negedge clk);
    #1;
    proc_read = 1'b1;
    proc_addr = 30'h0000010;
    cycles    = 0;
    #1;
    while (!mem_read && cycles < 20) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    checkOutput("fill_started", {127'd0, mem_read}, 128'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mem_rd", {127'd0, mem_read},   128'd0);
    checkOutput("midrst_stall",  {127'd0, proc_stall}, 128'd0);
    checkOutput("midrst_maddr",  {100'd0, mem_addr},   128'd0);
    clear_model();
    proc_read = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 30'h0000010, 32'h0);

    // Mixed traffic over four tags across all indices; rd+wr counts as store.
    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [29:0] a;
      kind = $urandom_range(0, 2);
      a = 30'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      applyStimulus(kind != 1, kind != 0, a, $urandom);
    end

    checkOutput("txn_q_empty", 128'(exp_txn.size()), 128'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
